// File: rtl/mmuart_pkg.sv
// mmuart_pkg: dispatcher state encoding and UART data width shared by the mmuart TX and RX FIFOs
package mmuart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ISSUE = 2'd2, WAIT = 2'd3} mmuart_state_t;
endpackage

// File: rtl/mmuart_fifo_mem.sv
// mmuart_fifo_mem: DEPTH x DATA_W storage (clk, we/waddr/wdata write port, raddr/rdata combinational read port)
module mmuart_fifo_mem import mmuart_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mmuart_tx_fifo.sv
// mmuart_tx_fifo: TX byte FIFO (wr_en/wr_data/flush/ovf_clr in; full/empty/level/low_water/overflow/drained status) feeding the transceiver via tx_data/tx_wr/tx_done, gated by cts_n
module mmuart_tx_fifo import mmuart_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int FLOW_EN = 1,
  parameter int LOW_WATER = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              ovf_clr,
  input  logic              cts_n,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              low_water,
  output logic              overflow,
  output logic              drained,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_done
);
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [1:0] cts_sync;
  logic [DATA_W-1:0] rd_data;
  logic cts_ok;
  logic do_wr;
  mmuart_state_t state;
  assign level = wr_ptr - rd_ptr;
  assign empty = level == '0;
  assign full = level == (ADDR_W+1)'(DEPTH);
  assign low_water = int'(level) <= LOW_WATER;
  assign drained = empty && state == IDLE;
  assign cts_ok = FLOW_EN == 0 || !cts_sync[1];
  assign do_wr = wr_en && !full && !flush;
  mmuart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(sys_clk),
    .we(do_wr),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(rd_data)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cts_sync <= '1;
      overflow <= 1'b0;
      state <= IDLE;
      tx_data <= '0;
      tx_wr <= 1'b0;
    end else begin
      cts_sync <= {cts_sync[0], cts_n};
      wr_ptr <= wr_ptr + (ADDR_W+1)'(do_wr);
      rd_ptr <= flush ? wr_ptr : rd_ptr + (ADDR_W+1)'(state == LOAD);
      overflow <= (wr_en && full && !flush) || (overflow && !ovf_clr);
      tx_wr <= state == LOAD;
      if (state == LOAD) tx_data <= rd_data;
      state <= state == IDLE  ? (!empty && cts_ok && !flush ? LOAD : IDLE) :
               state == LOAD  ? ISSUE :
               state == ISSUE ? WAIT :
               tx_done        ? IDLE : WAIT;
    end
endmodule

// File: tb/tb_mmuart_tx_fifo.sv
// tb_mmuart_tx_fifo: scoreboard bench for the mmuart TX FIFO and dispatcher
module tb_mmuart_tx_fifo;
  localparam int DEPTH = 16;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic wr_en;
  logic [7:0] wr_data;
  logic flush;
  logic ovf_clr;
  logic cts_n;
  logic full;
  logic empty;
  logic [4:0] level;
  logic low_water;
  logic overflow;
  logic drained;
  logic [7:0] tx_data;
  logic tx_wr;
  logic tx_done;
  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int auto_dly = 0;
  int man_req = 0;
  int man_ack = 0;
  int cnt = 0;
  mmuart_tx_fifo #(.DEPTH(DEPTH), .FLOW_EN(1), .LOW_WATER(4)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .flush(flush),
    .ovf_clr(ovf_clr),
    .cts_n(cts_n),
    .full(full),
    .empty(empty),
    .level(level),
    .low_water(low_water),
    .overflow(overflow),
    .drained(drained),
    .tx_data(tx_data),
    .tx_wr(tx_wr),
    .tx_done(tx_done)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  task automatic pulse_done();
    man_req++;
    tick();
  endtask
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      tx_done = 1'b0;
      if (tx_wr) begin
        n_wr++;
        if (exp_q.size() == 0) check("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
        else check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
        cnt = auto_dly;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
      if (man_req != man_ack) begin
        man_ack = man_req;
        tx_done = 1'b1;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int base;
    int lat;
    int lvl;
    int sent;
    sys_rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    ovf_clr = 1'b0;
    cts_n = 1'b0;
    #2;
    check("rst_tx_wr", 32'(tx_wr), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_level", 32'(level), 0);
    check("rst_low_water", 32'(low_water), 1);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drained", 32'(drained), 1);
    sys_rst_n = 1'b1;
    tick(4);
    base = n_wr;
    exp_q.push_back(8'h55);
    wr_en = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("sb_level", 32'(level), 1);
    check("sb_busy", 32'(drained), 0);
    tick();
    check("sb_no_early_wr", 32'(tx_wr), 0);
    tick();
    check("sb_tx_wr", 32'(tx_wr), 1);
    check("sb_tx_data", 32'(tx_data), 32'h55);
    tick();
    check("sb_tx_wr_single", 32'(tx_wr), 0);
    tick(5);
    check("sb_wait_busy", 32'(drained), 0);
    pulse_done();
    check("sb_drained", 32'(drained), 1);
    check("sb_wr_count", n_wr - base, 1);
    base = n_wr;
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      if (i < 17) exp_q.push_back(8'(i));
      tick();
      lvl = i < 2 ? i + 1 : (i <= 16 ? i : 16);
      check("fill_level", 32'(level), lvl);
      check("fill_full", 32'(full), 32'(lvl == DEPTH));
      check("fill_overflow", 32'(overflow), 32'(i == 17));
    end
    wr_en = 1'b1;
    ovf_clr = 1'b1;
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(overflow), 1);
    check("ovf_level", 32'(level), 16);
    for (int m = 1; m <= 17; m++) begin
      pulse_done();
      if (m < 17) begin
        tick(3);
        check("drain_level", 32'(level), 16 - m);
        check("drain_low_water", 32'(low_water), 32'(16 - m <= 4));
      end
    end
    check("drain_drained", 32'(drained), 1);
    check("drain_count", n_wr - base, 17);
    check("drain_queue", exp_q.size(), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clear", 32'(overflow), 0);
    cts_n = 1'b1;
    tick(4);
    base = n_wr;
    exp_q.push_back(8'hA5);
    wr_en = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    tick(100);
    check("cts_hold", n_wr - base, 0);
    check("cts_level", 32'(level), 1);
    cts_n = 1'b0;
    lat = 0;
    while (lat < 10 && !tx_wr) begin
      tick();
      lat++;
    end
    check("cts_latency", lat, 4);
    tick();
    pulse_done();
    check("cts_drained", 32'(drained), 1);
    base = n_wr;
    exp_q.push_back(8'h30);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick();
    end
    wr_en = 1'b0;
    check("fl_inflight", n_wr - base, 1);
    check("fl_level_pre", 32'(level), 4);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("fl_level", 32'(level), 0);
    check("fl_empty", 32'(empty), 1);
    check("fl_overflow", 32'(overflow), 0);
    check("fl_busy", 32'(drained), 0);
    tick(10);
    check("fl_no_wr", n_wr - base, 1);
    pulse_done();
    check("fl_drained", 32'(drained), 1);
    tick(10);
    check("fl_no_more", n_wr - base, 1);
    check("fl_queue", exp_q.size(), 0);
    base = n_wr;
    auto_dly = 10;
    sent = 0;
    lat = 0;
    while (sent < 100 && lat < 5000) begin
      if (!full) begin
        wr_en = 1'b1;
        wr_data = 8'(sent * 37 + 11);
        exp_q.push_back(8'(sent * 37 + 11));
        sent++;
      end else wr_en = 1'b0;
      tick();
      lat++;
    end
    wr_en = 1'b0;
    check("wrap_sent", sent, 100);
    lat = 0;
    while ((!drained || exp_q.size() != 0) && lat < 5000) begin
      tick();
      lat++;
    end
    check("wrap_count", n_wr - base, 100);
    check("wrap_queue", exp_q.size(), 0);
    check("wrap_drained", 32'(drained), 1);
    check("wrap_overflow", 32'(overflow), 0);
    auto_dly = 0;
    tick(2);
    base = n_wr;
    exp_q.push_back(8'h61);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h61 + i);
      tick();
    end
    wr_en = 1'b0;
    tick(2);
    check("rw_level", 32'(level), 3);
    check("rw_inflight", n_wr - base, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("ar_empty", 32'(empty), 1);
    check("ar_tx_wr", 32'(tx_wr), 0);
    check("ar_drained", 32'(drained), 1);
    check("ar_level", 32'(level), 0);
    check("ar_tx_data", 32'(tx_data), 0);
    check("ar_full", 32'(full), 0);
    #2 sys_rst_n = 1'b1;
    tick(10);
    check("ar_no_wr", n_wr - base, 1);
    check("ar_queue", exp_q.size(), 0);
    check("ar_still_drained", 32'(drained), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
